// File: rtl/multi_channel_trigger_core.sv
// Per-channel self-trigger: registered hit detection, then a window FSM
// with pre/post extension, window merge, timeout and re-arm.
module multi_channel_trigger_core #(
    parameter int CHANNEL_NUM                 = 4,
    parameter int SAMPLE_NUM_PER_CLK          = 8,
    parameter int SAMPLE_WIDTH                = 16,
    parameter int ADC_RESOLUTION_WIDTH        = 12,
    parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
    parameter int MAX_POST_ACQUISITION_LENGTH = 2,
    parameter int MAX_TRIGGER_LENGTH          = 256
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic SET_CONFIG,
    input  logic STOP,
    input  logic [CHANNEL_NUM-1:0] CH_ENABLE,
    input  logic [CHANNEL_NUM*SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [CHANNEL_NUM-1:0] S_AXIS_TVALID,
    input  logic [CHANNEL_NUM*SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0] H_S_AXIS_TDATA,
    input  logic signed [SAMPLE_WIDTH-1:0] RISING_EDGE_THRESHOLD,
    input  logic signed [SAMPLE_WIDTH-1:0] FALLING_EDGE_THRESHOLD,
    input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0] PRE_ACQUISITION_LENGTH,
    input  logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0] POST_ACQUISITION_LENGTH,
    output logic [CHANNEL_NUM-1:0] TRIGGER,
    output logic [CHANNEL_NUM-1:0] SATURATION_FLAG,
    output logic [CHANNEL_NUM-1:0] TIMEOUT_FLAG
);

    localparam int WORD_W = SAMPLE_NUM_PER_CLK * SAMPLE_WIDTH;
    localparam int ADC_W  = ADC_RESOLUTION_WIDTH;
    localparam int EXT_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH
                                   + MAX_POST_ACQUISITION_LENGTH + 1);
    localparam int LEN_W  = $clog2(MAX_TRIGGER_LENGTH + 1);
    localparam logic [ADC_W-1:0] SAT_POS = {1'b0, {(ADC_W-1){1'b1}}};
    localparam logic [ADC_W-1:0] SAT_NEG = {1'b1, {(ADC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACTIVE, EXTEND, REARM} state_t;

    logic [EXT_W-1:0] pre_len;
    logic [EXT_W-1:0] post_len;
    logic [EXT_W-1:0] ext_len;

    always_comb begin
        pre_len  = EXT_W'(PRE_ACQUISITION_LENGTH);
        post_len = EXT_W'(POST_ACQUISITION_LENGTH);
        if (int'(PRE_ACQUISITION_LENGTH) > MAX_PRE_ACQUISITION_LENGTH)
            pre_len = EXT_W'(MAX_PRE_ACQUISITION_LENGTH);
        if (int'(POST_ACQUISITION_LENGTH) > MAX_POST_ACQUISITION_LENGTH)
            post_len = EXT_W'(MAX_POST_ACQUISITION_LENGTH);
        ext_len = pre_len + post_len;
    end

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
        logic signed [SAMPLE_WIDTH-1:0] smp;
        logic [ADC_W-1:0] hsmp;
        logic hit_raw, end_raw, sat_raw;
        logic hit_q, hit_d, end_q, end_d;
        logic sat_q, sat_d, vld_q, vld_d;
        state_t state_q, state_d;
        logic [LEN_W-1:0] len_q, len_d;
        logic [EXT_W-1:0] ext_q, ext_d;
        logic rearm_q, rearm_d;
        logic trig_q, trig_d;
        logic satf_q, satf_d;
        logic tout_q, tout_d;
        logic arm, leave;

        always_comb begin
            smp     = '0;
            hsmp    = '0;
            hit_raw = 1'b0;
            end_raw = 1'b1;
            sat_raw = 1'b0;
            for (int i = 0; i < SAMPLE_NUM_PER_CLK; i++) begin
                smp  = S_AXIS_TDATA[c*WORD_W + i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                hsmp = H_S_AXIS_TDATA[c*WORD_W + i*SAMPLE_WIDTH
                                      + SAMPLE_WIDTH - ADC_W +: ADC_W];
                if (smp > RISING_EDGE_THRESHOLD)
                    hit_raw = 1'b1;
                if (!(smp < FALLING_EDGE_THRESHOLD))
                    end_raw = 1'b0;
                if (hsmp == SAT_POS || hsmp == SAT_NEG)
                    sat_raw = 1'b1;
            end
            vld_d = S_AXIS_TVALID[c];
            hit_d = vld_d & (hit_raw | sat_raw);
            end_d = vld_d & end_raw;
            sat_d = vld_d & sat_raw;
            if (SET_CONFIG) begin
                vld_d = 1'b0;
                hit_d = 1'b0;
                end_d = 1'b0;
                sat_d = 1'b0;
            end
        end

        always_comb begin
            state_d = state_q;
            len_d   = len_q;
            ext_d   = ext_q;
            rearm_d = rearm_q;
            tout_d  = 1'b0;
            leave   = 1'b0;
            arm     = hit_q & CH_ENABLE[c] & ~STOP & vld_q;
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = ACTIVE;
                        len_d   = LEN_W'(1);
                    end
                end
                ACTIVE: begin
                    len_d = len_q + LEN_W'(1);
                    if (end_q || !vld_q) begin
                        leave = 1'b1;
                    end else if (len_q == LEN_W'(MAX_TRIGGER_LENGTH)) begin
                        leave   = 1'b1;
                        rearm_d = 1'b1;
                        tout_d  = 1'b1;
                    end
                    // no extension configured: close the window immediately
                    if (leave) begin
                        if (ext_len == '0) begin
                            state_d = rearm_d ? REARM : IDLE;
                        end else begin
                            state_d = EXTEND;
                            ext_d   = EXT_W'(1);
                        end
                    end
                end
                EXTEND: begin
                    if (arm && !rearm_q) begin
                        state_d = ACTIVE;
                        len_d   = LEN_W'(1);
                    end else if (ext_q >= ext_len) begin
                        state_d = rearm_q ? REARM : IDLE;
                    end else begin
                        ext_d = ext_q + EXT_W'(1);
                    end
                end
                REARM: begin
                    if (end_q && vld_q) begin
                        state_d = IDLE;
                        rearm_d = 1'b0;
                    end
                end
            endcase
            trig_d = (state_d == ACTIVE) || (state_d == EXTEND);
            satf_d = trig_d & (satf_q | sat_q);
            if (SET_CONFIG) begin
                state_d = IDLE;
                len_d   = '0;
                ext_d   = '0;
                rearm_d = 1'b0;
                tout_d  = 1'b0;
                trig_d  = 1'b0;
                satf_d  = 1'b0;
            end
        end

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                hit_q   <= 1'b0;
                end_q   <= 1'b0;
                sat_q   <= 1'b0;
                vld_q   <= 1'b0;
                state_q <= IDLE;
                len_q   <= '0;
                ext_q   <= '0;
                rearm_q <= 1'b0;
                trig_q  <= 1'b0;
                satf_q  <= 1'b0;
                tout_q  <= 1'b0;
            end else begin
                hit_q   <= hit_d;
                end_q   <= end_d;
                sat_q   <= sat_d;
                vld_q   <= vld_d;
                state_q <= state_d;
                len_q   <= len_d;
                ext_q   <= ext_d;
                rearm_q <= rearm_d;
                trig_q  <= trig_d;
                satf_q  <= satf_d;
                tout_q  <= tout_d;
            end
        end

        assign TRIGGER[c]         = trig_q;
        assign SATURATION_FLAG[c] = satf_q;
        assign TIMEOUT_FLAG[c]    = tout_q;
    end

endmodule
